// File: rtl/tohost_reporter.sv
// tohost_reporter: watches core stores to the tohost mailbox and turns them
// into one latched test verdict (pass / fail number / watchdog timeout). The
// verdict is offered on a valid/ready handshake and a sticky halt is raised
// toward the core as soon as a verdict exists.
module tohost_reporter #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_en,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        result_pass,
    output logic        result_timeout,
    output logic [30:0] result_testnum,
    output logic [31:0] result_cycles,
    output logic        halt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REPORT = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cnt;
    logic        hit;
    logic        exit_ev;
    logic        tmo_ev;
    logic        verdict_ev;

    // A store to the mailbox; only odd values are exit codes, even values
    // (zero or syscall pointers) are left alone.
    assign hit        = st_en && (st_addr == TOHOST_ADDR);
    assign verdict_ev = exit_ev || tmo_ev;

    // Next-state decode; an exit store beats a watchdog expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        exit_ev   = 1'b0;
        tmo_ev    = 1'b0;
        case (state)
            RUN: begin
                exit_ev = hit && st_data[0];
                tmo_ev  = !exit_ev && (cnt == TIMEOUT_CYCLES - 32'd1);
                if (exit_ev || tmo_ev) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                // result_valid is already high in REPORT, so ready here is a real handshake.
                if (result_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State register; DONE is left only through reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // RUN cycle counter; frozen once a verdict exists. It cannot wrap because
    // the watchdog fires at TIMEOUT_CYCLES-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 32'd0;
        end else if ((state == RUN) && !verdict_ev) begin
            cnt <= cnt + 32'd1;
        end
    end

    // Verdict fields are captured once, on the event edge, and then held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_pass    <= 1'b0;
            result_timeout <= 1'b0;
            result_testnum <= 31'd0;
            result_cycles  <= 32'd0;
        end else if ((state == RUN) && verdict_ev) begin
            result_pass    <= exit_ev && (st_data[31:1] == 31'd0);
            result_timeout <= tmo_ev;
            result_testnum <= exit_ev ? st_data[31:1] : 31'd0;
            result_cycles  <= cnt;
        end
    end

    // Registered handshake valid and sticky halt request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_valid <= 1'b0;
            halt         <= 1'b0;
        end else begin
            result_valid <= (state_nxt == REPORT);
            halt         <= halt || (state_nxt != RUN);
        end
    end

endmodule

// File: tb/tb_tohost_reporter.sv
// Bench for tohost_reporter: directed scenarios plus randomized store traffic,
// all checked against a verdict-level reference model.
module tb_tohost_reporter;

    localparam logic [31:0] A  = 32'h0000_1000;
    localparam int unsigned TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st_en = 1'b0;
    logic [31:0] st_addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    logic        result_ready = 1'b0;
    logic        result_valid;
    logic        result_pass;
    logic        result_timeout;
    logic [30:0] result_testnum;
    logic [31:0] result_cycles;
    logic        halt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: does a verdict exist, was it accepted, what is it.
    int unsigned m_cnt;
    bit          m_have;
    bit          m_acc;
    bit          m_pass;
    bit          m_to;
    logic [30:0] m_tn;
    logic [31:0] m_cyc;

    tohost_reporter #(.TOHOST_ADDR(A), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_pass(result_pass), .result_timeout(result_timeout),
        .result_testnum(result_testnum), .result_cycles(result_cycles), .halt(halt)
    );

    always #5 clk = ~clk;

    wire [66:0] obs = {result_valid, result_pass, result_timeout, result_testnum, result_cycles, halt};

    function automatic logic [66:0] expv();
        return {logic'(m_have && !m_acc), logic'(m_pass), logic'(m_to), m_tn, m_cyc, logic'(m_have)};
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_have = 0; m_acc = 0; m_pass = 0; m_to = 0; m_tn = '0; m_cyc = '0;
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_edge(input logic en, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        if (!m_have) begin
            if (en && a == A && d[0]) begin
                m_have = 1; m_pass = (d[31:1] == 0); m_to = 0; m_tn = d[31:1]; m_cyc = m_cnt;
            end else if (m_cnt == TO - 1) begin
                m_have = 1; m_pass = 0; m_to = 1; m_tn = '0; m_cyc = m_cnt;
            end else begin
                m_cnt++;
            end
        end else if (!m_acc && rdy) begin
            m_acc = 1;
        end
    endtask

    // Drive one cycle of inputs; returns at the following falling edge.
    task automatic step(input logic en, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        st_en = en; st_addr = a; st_data = d; result_ready = rdy;
        @(posedge clk);
        model_edge(en, a, d, rdy);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // Assert reset part-way through a low phase; outputs must clear without a clock.
    task automatic assert_rst();
        @(negedge clk);
        #2;
        rst = 1'b0; st_en = 1'b0; result_ready = 1'b0;
        model_clear();
        #1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        assert_rst();
        vectors++;
        if (obs !== 67'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want 0", obs);
        end
        release_rst();
        idle(3);
        vectors++;
        if (obs !== expv() || halt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle got %h want %h", obs, expv());
        end
    endtask

    task automatic test_pass();
        assert_rst(); release_rst();
        idle(20);
        step(1'b1, A, 32'h1, 1'b0);
        vectors++;
        if (obs !== {1'b1, 1'b1, 1'b0, 31'd0, 32'd20, 1'b1} || obs !== expv()) begin
            miscompares++;
            $display("FAIL pass_verdict got %h want %h", obs, expv());
        end
        step(1'b0, 32'd0, 32'd0, 1'b1);
        vectors++;
        if (result_valid !== 1'b0 || halt !== 1'b1 || obs !== expv()) begin
            miscompares++;
            $display("FAIL pass_accept got %h want %h", obs, expv());
        end
        idle(5);
        vectors++;
        if (obs !== expv()) begin
            miscompares++;
            $display("FAIL pass_done_hold got %h want %h", obs, expv());
        end
    endtask

    task automatic test_fail();
        assert_rst(); release_rst();
        idle(7);
        step(1'b1, A, 32'h0000_000B, 1'b0);
        vectors++;
        if (result_pass !== 1'b0 || result_testnum !== 31'd5 || result_timeout !== 1'b0 ||
            result_cycles !== 32'd7 || obs !== expv()) begin
            miscompares++;
            $display("FAIL fail_verdict got %h want %h", obs, expv());
        end
        step(1'b1, A, 32'h1, 1'b0);
        vectors++;
        if (obs !== expv() || result_testnum !== 31'd5) begin
            miscompares++;
            $display("FAIL fail_report_store got %h want %h", obs, expv());
        end
        step(1'b0, 32'd0, 32'd0, 1'b1);
        step(1'b1, A, 32'h1, 1'b0);
        vectors++;
        if (obs !== expv() || result_pass !== 1'b0 || result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fail_done_store got %h want %h", obs, expv());
        end
    endtask

    task automatic test_ignored();
        int n;
        assert_rst(); release_rst();
        step(1'b1, A + 32'd4, 32'h1, 1'b1);
        step(1'b1, A, 32'h0000_0100, 1'b1);
        step(1'b1, A, 32'h0, 1'b1);
        vectors++;
        if (result_valid !== 1'b0 || halt !== 1'b0 || obs !== expv()) begin
            miscompares++;
            $display("FAIL ignored_stores got %h want %h", obs, expv());
        end
        n = 3;
        while (result_valid !== 1'b1 && n < 200) begin
            step(1'b0, 32'd0, 32'd0, 1'b0);
            n++;
        end
        vectors++;
        if (n != int'(TO) || result_cycles !== 32'd99 || result_timeout !== 1'b1 || obs !== expv()) begin
            miscompares++;
            $display("FAIL ignored_counter edges %0d got %h want %h", n, obs, expv());
        end
    endtask

    task automatic test_timeout();
        int n;
        assert_rst(); release_rst();
        n = 0;
        while (result_valid !== 1'b1 && n < 200) begin
            step(1'b0, 32'd0, 32'd0, 1'b0);
            n++;
        end
        vectors++;
        if (n != int'(TO) || obs !== {1'b1, 1'b0, 1'b1, 31'd0, 32'd99, 1'b1}) begin
            miscompares++;
            $display("FAIL timeout_verdict edges %0d got %h want valid,to,cycles=99", n, obs);
        end
    endtask

    task automatic test_collision();
        assert_rst(); release_rst();
        idle(99);
        vectors++;
        if (result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL collision_early got %h want valid=0", obs);
        end
        step(1'b1, A, 32'h1, 1'b0);
        vectors++;
        if (obs !== {1'b1, 1'b1, 1'b0, 31'd0, 32'd99, 1'b1} || obs !== expv()) begin
            miscompares++;
            $display("FAIL collision_verdict got %h want %h", obs, expv());
        end
    endtask

    task automatic test_backpressure_reset();
        logic [66:0] held;
        assert_rst(); release_rst();
        idle(5);
        step(1'b1, A, 32'h5, 1'b0);
        held = obs;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, A, 32'h1, 1'b0);
            vectors++;
            if (obs !== held || obs !== expv()) begin
                miscompares++;
                $display("FAIL backpressure_hold cycle %0d got %h want %h", i, obs, held);
            end
        end
        assert_rst();
        vectors++;
        if (obs !== 67'd0) begin
            miscompares++;
            $display("FAIL midreport_reset got %h want 0", obs);
        end
        release_rst();
        step(1'b1, A, 32'h3, 1'b0);
        vectors++;
        if (result_testnum !== 31'd1 || result_pass !== 1'b0 || result_cycles !== 32'd0 || obs !== expv()) begin
            miscompares++;
            $display("FAIL post_reset_verdict got %h want %h", obs, expv());
        end
    endtask

    task automatic test_random();
        logic        en;
        logic [31:0] a;
        logic [31:0] d;
        for (int r = 0; r < 12; r++) begin
            assert_rst(); release_rst();
            for (int c = 0; c < int'($urandom_range(60, 220)); c++) begin
                en = ($urandom_range(0, 9) < 3);
                case ($urandom_range(0, 3))
                    0, 1:    a = A;
                    2:       a = A + 32'd4;
                    default: a = $urandom;
                endcase
                d[0] = ($urandom_range(0, 4) == 0);
                d[31:1] = ($urandom_range(0, 2) == 0) ? 31'd0 : 31'($urandom);
                step(en, a, d, 1'($urandom_range(0, 3) == 0));
                vectors++;
                if (obs !== expv()) begin
                    miscompares++;
                    $display("FAIL random r%0d c%0d got %h want %h", r, c, obs, expv());
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_pass();
        test_fail();
        test_ignored();
        test_timeout();
        test_collision();
        test_backpressure_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
